uart_rx_oversample: RTL and testbench

- UART receiver; the receive-side consumer of the baud timing produced by the bitrate generator.
- Samples the asynchronous serial line on a 16x (OVERSAMPLE) tick and reassembles LSB-first frames into parallel bytes.
- Delivers each byte through a hold register with a valid/ack handshake.
- Sits between the pad-side rx line and the CPU-side register interface, in the clk_CPU domain.

---
 rtl/uart_rx_oversample.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// UART receiver: 2-flop line synchronizer, 16x-oversampled frame FSM and a valid/ack hold register.
// Build option: define UART_RX_PARITY_EN to insert a parity bit check between the data and stop bits.
module uart_rx_oversample #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk_CPU,
   input  logic                 RST_RX,
   input  logic                 EN,
   input  logic                 tick_os,
   input  logic                 rx,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 parity_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bitCnt_q, bitCnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   rxMeta_q, rxs_q;
   logic                   deliver_q, deliver_d;
   logic                   frameErr_q, frameErr_d;
   logic                   overrun_q;
   logic                   rxValid_q;
   logic [DATA_BITS-1:0]   rxData_q;
`ifdef UART_RX_PARITY_EN
   logic                   parityErr_q, parityErr_d;
   logic                   parBad_q, parBad_d;
`endif

   // Sequential state; the synchronizer resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk_CPU or posedge RST_RX) begin
      if (RST_RX) begin
         rxMeta_q   <= 1'b1;
         rxs_q      <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= '0;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         deliver_q  <= 1'b0;
         frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErr_q <= 1'b0;
         parBad_q    <= 1'b0;
`endif
      end else begin
         rxMeta_q   <= rx;
         rxs_q      <= rxMeta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         deliver_q  <= deliver_d;
         frameErr_q <= frameErr_d;
`ifdef UART_RX_PARITY_EN
         parityErr_q <= parityErr_d;
         parBad_q    <= parBad_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bitCnt_d   = bitCnt_q;
      shift_d    = shift_q;
      deliver_d  = 1'b0;
      frameErr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr_d = 1'b0;
      parBad_d    = parBad_q;
`endif
      if (tick_os && state_q != IDLE && state_q != BREAK) begin
         cnt_d = cnt_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (!rxs_q) begin
               state_d = START;
               cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
               parBad_d = 1'b0;
`endif
            end
         end
         START: begin
            if (tick_os && cnt_q == MID_TICK) begin
               cnt_d    = '0;
               bitCnt_d = '0;
               state_d  = rxs_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick_os && cnt_q == LAST_TICK) begin
               cnt_d   = '0;
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
               if (bitCnt_q == LAST_BIT) begin
                  bitCnt_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d  = PARITY;
`else
                  state_d  = STOP;
`endif
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick_os && cnt_q == LAST_TICK) begin
               cnt_d   = '0;
               state_d = STOP;
               if (rxs_q != ((^shift_q) ^ PARITY_ODD[0])) begin
                  parityErr_d = 1'b1;
                  parBad_d    = 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (tick_os && cnt_q == LAST_TICK) begin
               cnt_d = '0;
               if (rxs_q) begin
                  state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                  deliver_d = !parBad_q;
`else
                  deliver_d = 1'b1;
`endif
               end else begin
                  state_d    = BREAK;
                  frameErr_d = 1'b1;
               end
            end
         end
         BREAK: begin
            if (rxs_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Disabling aborts the frame silently; an already pending delivery still completes.
      if (!EN) begin
         state_d    = IDLE;
         cnt_d      = '0;
         bitCnt_d   = '0;
         frameErr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErr_d = 1'b0;
         parBad_d    = 1'b0;
`endif
      end
   end

   // Hold register: a delivery coinciding with an ack replaces the byte, otherwise a full register drops it.
   always_ff @(posedge clk_CPU or posedge RST_RX) begin
      if (RST_RX) begin
         rxData_q  <= '0;
         rxValid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (deliver_q) begin
            if (!rxValid_q || rx_ack) begin
               rxData_q  <= shift_q;
               rxValid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (rxValid_q && rx_ack) begin
            rxValid_q <= 1'b0;
         end
      end
   end

   assign rx_data     = rxData_q;
   assign rx_valid    = rxValid_q;
   assign busy        = (state_q != IDLE);
   assign frame_err   = frameErr_q;
   assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parityErr_q;
`else
   assign parity_err  = PARITY_ODD[0] & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed scenarios plus randomized frames against a
// frame-level model of the hold register. Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx_oversample;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;
   localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // Negedge at which rx_valid is first seen high, counted in posedges from the negedge where rx drops:
   // first capturing edge, 2 sync flops, the IDLE->START edge is absorbed in the half-bit, then bits, then delivery.
   localparam int RISE_OFS = 1 + 2 + OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + PAR_BITS + 1) + 1;

   logic                 clk_CPU;
   logic                 RST_RX;
   logic                 EN;
   logic                 tick_os;
   logic                 rx;
   logic                 rx_ack;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 busy;
   logic                 frame_err;
   logic                 overrun_err;
   logic                 parity_err;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int frameErrCnt = 0;
   int overrunCnt = 0;
   int parErrCnt = 0;
   int lastRise = -1;
   logic prevValid = 1'b0;

   uart_rx_oversample #(
      .DATA_BITS  (DATA_BITS),
      .OVERSAMPLE (OVERSAMPLE),
      .PARITY_ODD (PARITY_ODD)
   ) dut (
      .clk_CPU     (clk_CPU),
      .RST_RX      (RST_RX),
      .EN          (EN),
      .tick_os     (tick_os),
      .rx          (rx),
      .rx_ack      (rx_ack),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err)
   );

   initial clk_CPU = 1'b0;
   always #5 clk_CPU = ~clk_CPU;

   always @(posedge clk_CPU) cyc <= cyc + 1;

   // Pulse counters and rx_valid rise time, sampled on the inactive edge.
   always @(negedge clk_CPU) begin
      if (frame_err) frameErrCnt++;
      if (overrun_err) overrunCnt++;
      if (parity_err) parErrCnt++;
      if (rx_valid && !prevValid) lastRise = cyc;
      prevValid = rx_valid;
   end

   function automatic logic parOf(input logic [7:0] d);
      return (^d) ^ 1'(PARITY_ODD);
   endfunction

   // Drives one frame LSB-first, OVERSAMPLE clocks per bit (tick_os is held high); call at a negedge.
   task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic parBit);
      rx = 1'b0;
      repeat (OVERSAMPLE) @(negedge clk_CPU);
      for (int i = 0; i < DATA_BITS; i++) begin
         rx = d[i];
         repeat (OVERSAMPLE) @(negedge clk_CPU);
      end
`ifdef UART_RX_PARITY_EN
      rx = parBit;
      repeat (OVERSAMPLE) @(negedge clk_CPU);
`else
      if (parBit === 1'bz) rx = 1'b1;
`endif
      rx = stopBit;
      repeat (OVERSAMPLE) @(negedge clk_CPU);
      rx = 1'b1;
   endtask

   task automatic ackPulse();
      rx_ack = 1'b1;
      @(negedge clk_CPU);
      rx_ack = 1'b0;
      @(negedge clk_CPU);
   endtask

   task automatic test_reset();
      RST_RX = 1'b1;
      repeat (3) @(negedge clk_CPU);
      checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_data got=%h exp=00", rx_data); end
      checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
         fails++; $display("[TB] FAIL reset_pulses got=%b exp=000", {frame_err, overrun_err, parity_err});
      end
      RST_RX = 1'b0;
      repeat (3) @(negedge clk_CPU);
   endtask

   task automatic test_basic();
      int c0, fe0, ov0;
      fe0 = frameErrCnt; ov0 = overrunCnt; c0 = cyc;
      sendFrame(8'hA5, 1'b1, parOf(8'hA5));
      repeat (4) @(negedge clk_CPU);
      checks++; if (lastRise !== c0 + RISE_OFS) begin
         fails++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lastRise - c0, RISE_OFS);
      end
      checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid got=%b exp=1", rx_valid); end
      checks++; if (rx_data !== 8'hA5) begin fails++; $display("[TB] FAIL basic_data got=%h exp=a5", rx_data); end
      checks++; if (frameErrCnt !== fe0 || overrunCnt !== ov0) begin
         fails++; $display("[TB] FAIL basic_errors got fe=%0d ov=%0d exp=0", frameErrCnt - fe0, overrunCnt - ov0);
      end
      ackPulse();
      checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_ack got=%b exp=0", rx_valid); end
   endtask

   task automatic test_overrun();
      int ov0;
      ov0 = overrunCnt;
      sendFrame(8'h3C, 1'b1, parOf(8'h3C));
      sendFrame(8'hC3, 1'b1, parOf(8'hC3));
      repeat (4) @(negedge clk_CPU);
      checks++; if (rx_data !== 8'h3C) begin fails++; $display("[TB] FAIL overrun_data got=%h exp=3c", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL overrun_valid got=%b exp=1", rx_valid); end
      checks++; if (overrunCnt - ov0 !== 1) begin
         fails++; $display("[TB] FAIL overrun_pulses got=%0d exp=1", overrunCnt - ov0);
      end
      ackPulse();
      checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL overrun_ack got=%b exp=0", rx_valid); end
   endtask

   task automatic test_simul_ack();
      int c0, ov0;
      sendFrame(8'h42, 1'b1, parOf(8'h42));
      repeat (4) @(negedge clk_CPU);
      checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL simul_pre_valid got=%b exp=1", rx_valid); end
      ov0 = overrunCnt; c0 = cyc;
      fork
         sendFrame(8'h81, 1'b1, parOf(8'h81));
         begin
            while (cyc < c0 + RISE_OFS - 1) @(negedge clk_CPU);
            rx_ack = 1'b1;
            @(negedge clk_CPU);
            rx_ack = 1'b0;
         end
      join
      repeat (4) @(negedge clk_CPU);
      checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL simul_valid got=%b exp=1", rx_valid); end
      checks++; if (rx_data !== 8'h81) begin fails++; $display("[TB] FAIL simul_data got=%h exp=81", rx_data); end
      checks++; if (overrunCnt !== ov0) begin fails++; $display("[TB] FAIL simul_overrun got=%0d exp=0", overrunCnt - ov0); end
      ackPulse();
   endtask

   task automatic test_glitch_break();
      int fe0;
      fe0 = frameErrCnt;
      rx = 1'b0;
      repeat (4) @(negedge clk_CPU);
      rx = 1'b1;
      repeat (4) @(negedge clk_CPU);
      checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL glitch_busy_start got=%b exp=1", busy); end
      repeat (4) @(negedge clk_CPU);
      checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL glitch_busy_end got=%b exp=0", busy); end
      sendFrame(8'h55, 1'b0, parOf(8'h55));
      rx = 1'b0;
      repeat (40) @(negedge clk_CPU);
      checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL break_busy got=%b exp=1", busy); end
      checks++; if (frameErrCnt - fe0 !== 1) begin
         fails++; $display("[TB] FAIL frame_err_pulses got=%0d exp=1", frameErrCnt - fe0);
      end
      checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL frame_err_valid got=%b exp=0", rx_valid); end
      rx = 1'b1;
      repeat (4) @(negedge clk_CPU);
      checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL break_exit got=%b exp=0", busy); end
   endtask

   task automatic test_abort();
      int c0, fe0, ov0, pe0;
      fe0 = frameErrCnt; ov0 = overrunCnt; pe0 = parErrCnt; c0 = cyc;
      fork
         sendFrame(8'hF0, 1'b1, parOf(8'hF0));
         begin
            while (cyc < c0 + OVERSAMPLE * 4 + OVERSAMPLE / 2) @(negedge clk_CPU);
            checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL abort_busy_pre got=%b exp=1", busy); end
            EN = 1'b0;
            @(negedge clk_CPU);
            checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
         end
      join
      EN = 1'b1;
      repeat (4) @(negedge clk_CPU);
      checks++; if (frameErrCnt !== fe0 || overrunCnt !== ov0 || parErrCnt !== pe0 || rx_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL abort_silent got fe=%0d ov=%0d pe=%0d valid=%b exp=0", frameErrCnt - fe0,
                           overrunCnt - ov0, parErrCnt - pe0, rx_valid);
      end
      sendFrame(8'h0F, 1'b1, parOf(8'h0F));
      repeat (4) @(negedge clk_CPU);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h0F) begin
         fails++; $display("[TB] FAIL abort_next got valid=%b data=%h exp valid=1 data=0f", rx_valid, rx_data);
      end
   endtask

   task automatic test_reset_midframe();
      int c0;
      checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL rst_pre_valid got=%b exp=1", rx_valid); end
      c0 = cyc;
      fork
         sendFrame(8'h99, 1'b1, parOf(8'h99));
         begin
            while (cyc < c0 + 50) @(negedge clk_CPU);
            RST_RX = 1'b1;
            #1;
            checks++; if ({rx_valid, busy} !== 2'b00 || rx_data !== 8'h00) begin
               fails++; $display("[TB] FAIL rst_async got valid=%b busy=%b data=%h exp 0", rx_valid, busy, rx_data);
            end
         end
      join
      RST_RX = 1'b0;
      repeat (4) @(negedge clk_CPU);
      checks++; if ({rx_valid, busy} !== 2'b00) begin
         fails++; $display("[TB] FAIL rst_after got valid=%b busy=%b exp 00", rx_valid, busy);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int pe0;
      pe0 = parErrCnt;
      sendFrame(8'h07, 1'b1, 1'b1);
      repeat (4) @(negedge clk_CPU);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h07 || parErrCnt !== pe0) begin
         fails++; $display("[TB] FAIL parity_good got valid=%b data=%h pe=%0d", rx_valid, rx_data, parErrCnt - pe0);
      end
      ackPulse();
      sendFrame(8'h07, 1'b1, 1'b0);
      repeat (4) @(negedge clk_CPU);
      checks++; if (rx_valid !== 1'b0 || parErrCnt - pe0 !== 1) begin
         fails++; $display("[TB] FAIL parity_bad got valid=%b pe=%0d exp valid=0 pe=1", rx_valid, parErrCnt - pe0);
      end
   endtask
`endif

   // Frame-level model: a good frame fills an empty hold register or counts an overrun; an ack empties it.
   task automatic test_random();
      logic [7:0] d, mData;
      logic stopBit, parBit, mValid, doAck;
      int fe0, ov0, pe0, expFe, expOv, expPe;
      ackPulse();
      mValid = 1'b0; mData = 8'h00;
      fe0 = frameErrCnt; ov0 = overrunCnt; pe0 = parErrCnt;
      expFe = 0; expOv = 0; expPe = 0;
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         stopBit = ($urandom_range(0, 3) != 0);
         parBit = parOf(d);
`ifdef UART_RX_PARITY_EN
         if ($urandom_range(0, 3) == 0) parBit = ~parBit;
`endif
         sendFrame(d, stopBit, parBit);
         repeat ($urandom_range(2, 6)) @(negedge clk_CPU);
         doAck = 1'($urandom_range(0, 1));
         if (PAR_BITS != 0 && parBit != parOf(d)) expPe++;
         if (!stopBit) expFe++;
         if (stopBit && (PAR_BITS == 0 || parBit == parOf(d))) begin
            if (mValid) expOv++;
            else begin mValid = 1'b1; mData = d; end
         end
         if (doAck) begin
            ackPulse();
            mValid = 1'b0;
         end
         checks++; if (rx_valid !== mValid) begin
            fails++; $display("[TB] FAIL rand_valid frame=%0d got=%b exp=%b", i, rx_valid, mValid);
         end
         if (mValid) begin
            checks++; if (rx_data !== mData) begin
               fails++; $display("[TB] FAIL rand_data frame=%0d got=%h exp=%h", i, rx_data, mData);
            end
         end
         checks++; if (frameErrCnt - fe0 !== expFe || overrunCnt - ov0 !== expOv || parErrCnt - pe0 !== expPe) begin
            fails++; $display("[TB] FAIL rand_pulses frame=%0d got fe=%0d ov=%0d pe=%0d exp fe=%0d ov=%0d pe=%0d", i,
                              frameErrCnt - fe0, overrunCnt - ov0, parErrCnt - pe0, expFe, expOv, expPe);
         end
      end
   endtask

   initial begin
      RST_RX = 1'b1; EN = 1'b1; tick_os = 1'b1; rx = 1'b1; rx_ack = 1'b0;
      test_reset();
      test_basic();
      test_overrun();
      test_simul_ack();
      test_glitch_break();
      test_abort();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
